// File: rtl/div_arbiter_pkg.sv
// div_arbiter_pkg: shared types and constants for the divider sequencing controller.
//   state_t : controller state (IDLE/RUN/HOLD)
//   NREQ    : number of requesters
//   DATA_W  : operand/result width
//   DIV_LAT : cycles from divider start to its complete pulse
package div_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int NREQ    = 2;
    localparam int DATA_W  = 32;
    localparam int DIV_LAT = 17;

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant, purely combinational.
//   req  : request vector
//   last : index of the most recently granted requester
//   gnt  : one-hot grant; on contention the requester other than last wins
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    assign gnt[0] = req[0] & (~req[1] | last);
    assign gnt[1] = req[1] & (~req[0] | ~last);

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: round-robin sequencing of two requesters onto one iterative divider.
//   clk, resetn                          : clock (shared with divider), async active-low reset
//   req_valid/ready/signed, req_x/req_y  : request handshake and operands, {port1, port0}
//   flush                                : per-requester kill of its outstanding op
//   rsp_valid/ready, rsp_q/r/dbz         : registered result, one-hot to the owner
//   busy                                 : an op is in flight or being held
//   dv_div/signed/x/y, dv_cancel         : divider start (grant cycle only) and abort
//   dv_s/dv_r/dv_complete                : divider result, valid during complete
module div_arbiter
    import div_arbiter_pkg::*;
(
    input  logic                clk,
    input  logic                resetn,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ-1:0]     req_signed,
    input  logic [2*DATA_W-1:0] req_x,
    input  logic [2*DATA_W-1:0] req_y,
    input  logic [NREQ-1:0]     flush,
    output logic [NREQ-1:0]     rsp_valid,
    input  logic [NREQ-1:0]     rsp_ready,
    output logic [DATA_W-1:0]   rsp_q,
    output logic [DATA_W-1:0]   rsp_r,
    output logic                rsp_dbz,
    output logic                busy,
    output logic                dv_div,
    output logic                dv_signed,
    output logic [DATA_W-1:0]   dv_x,
    output logic [DATA_W-1:0]   dv_y,
    input  logic [DATA_W-1:0]   dv_s,
    input  logic [DATA_W-1:0]   dv_r,
    input  logic                dv_complete,
    output logic                dv_cancel
);

    state_t            state;
    logic              owner;
    logic              last;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   grant;
    logic              win;
    logic              start;
    logic [DATA_W-1:0] x_win;
    logic [DATA_W-1:0] y_win;

    // A requester being flushed must not be granted in the same cycle.
    rr_arb2 u_arb (
        .req  (req_valid & ~flush),
        .last (last),
        .gnt  (gnt)
    );

    assign grant     = (state == IDLE) ? gnt : '0;
    assign req_ready = grant;
    assign start     = |grant;
    assign win       = grant[1];
    assign x_win     = win ? req_x[2*DATA_W-1:DATA_W] : req_x[DATA_W-1:0];
    assign y_win     = win ? req_y[2*DATA_W-1:DATA_W] : req_y[DATA_W-1:0];

    // Divider operands are zeroed outside the grant cycle so nothing stale leaks out.
    assign dv_div    = start;
    assign dv_signed = start & req_signed[win];
    assign dv_x      = start ? x_win : '0;
    assign dv_y      = start ? y_win : '0;
    assign dv_cancel = (state == RUN) & flush[owner];
    assign busy      = state != IDLE;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            owner     <= 1'b0;
            last      <= 1'b1;
            rsp_q     <= '0;
            rsp_r     <= '0;
            rsp_dbz   <= 1'b0;
            rsp_valid <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state   <= RUN;
                    owner   <= win;
                    last    <= win;
                    rsp_dbz <= y_win == '0;
                end
                // Flush wins over a same-cycle complete: the result is discarded.
                RUN: if (flush[owner]) begin
                    state <= IDLE;
                end else if (dv_complete) begin
                    state     <= HOLD;
                    rsp_q     <= dv_s;
                    rsp_r     <= dv_r;
                    rsp_valid <= owner ? 2'b10 : 2'b01;
                end
                HOLD: if (rsp_ready[owner] | flush[owner]) begin
                    state     <= IDLE;
                    rsp_valid <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a behavioural divider model.
module tb_div_arbiter;
    import div_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic [1:0]  req_valid, req_ready, req_signed, flush, rsp_valid, rsp_ready;
    logic [63:0] req_x, req_y;
    logic [31:0] rsp_q, rsp_r, dv_x, dv_y, dv_s, dv_r;
    logic        rsp_dbz, busy, dv_div, dv_signed, dv_complete, dv_cancel;

    int errors = 0;
    int checks = 0;
    int viol   = 0;

    always #5 clk = ~clk;

    div_arbiter dut (
        .clk         (clk),
        .resetn      (resetn),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_signed  (req_signed),
        .req_x       (req_x),
        .req_y       (req_y),
        .flush       (flush),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_q       (rsp_q),
        .rsp_r       (rsp_r),
        .rsp_dbz     (rsp_dbz),
        .busy        (busy),
        .dv_div      (dv_div),
        .dv_signed   (dv_signed),
        .dv_x        (dv_x),
        .dv_y        (dv_y),
        .dv_s        (dv_s),
        .dv_r        (dv_r),
        .dv_complete (dv_complete),
        .dv_cancel   (dv_cancel)
    );

    // Divider model: complete pulses DIV_LAT cycles after the start cycle.
    logic        m_active;
    int          m_cnt;
    logic [31:0] m_q, m_r;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_active <= 1'b0;
            m_cnt    <= 0;
            m_q      <= '0;
            m_r      <= '0;
        end else if (dv_cancel) begin
            m_active <= 1'b0;
        end else if (dv_div) begin
            m_active <= 1'b1;
            m_cnt    <= DIV_LAT - 1;
            if (dv_y == 0) begin
                m_q <= '1;
                m_r <= dv_x;
            end else if (dv_signed) begin
                m_q <= $signed(dv_x) / $signed(dv_y);
                m_r <= $signed(dv_x) % $signed(dv_y);
            end else begin
                m_q <= dv_x / dv_y;
                m_r <= dv_x % dv_y;
            end
        end else if (m_active) begin
            if (m_cnt == 0) m_active <= 1'b0;
            else m_cnt <= m_cnt - 1;
        end
    end

    assign dv_complete = m_active && (m_cnt == 0);
    assign dv_s        = m_q;
    assign dv_r        = m_r;

    // Protocol monitor: no start or accept while an op is active.
    always @(negedge clk) begin
        #2;
        if (resetn && busy && (dv_div || |req_ready)) viol++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk(tag, busy, 0);
    endtask

    logic [1:0] g [4];
    int         ng;
    logic       seen, stable;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 0; req_valid = 0; req_signed = 0; req_x = 0; req_y = 0; flush = 0; rsp_ready = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div", dv_div, 0);
        chk("rst_cancel", dv_cancel, 0);
        chk("rst_q", rsp_q, 0);
        @(negedge clk);
        resetn = 1;

        // Port 0 DIVU 100/7
        @(negedge clk);
        req_valid = 2'b01; req_signed = 0; req_x = {32'd0, 32'd100}; req_y = {32'd0, 32'd7}; rsp_ready = 2'b11;
        #1;
        chk("s1_ready", req_ready, 2'b01);
        chk("s1_div", dv_div, 1);
        chk("s1_x", dv_x, 100);
        chk("s1_y", dv_y, 7);
        chk("s1_signed", dv_signed, 0);
        @(negedge clk);
        req_valid = 0;
        #1;
        chk("s1_div_off", dv_div, 0);
        chk("s1_x_off", dv_x, 0);
        chk("s1_busy", busy, 1);
        seen = 0;
        repeat (16) begin
            @(negedge clk);
            #1;
            seen |= |rsp_valid;
        end
        chk("s1_early_rsp", seen, 0);
        @(negedge clk);
        #1;
        chk("s1_rsp_valid", rsp_valid, 2'b01);
        chk("s1_q", rsp_q, 14);
        chk("s1_r", rsp_r, 2);
        chk("s1_dbz", rsp_dbz, 0);
        @(negedge clk);
        #1;
        chk("s1_idle", busy, 0);

        // Port 1 DIV -7/2
        @(negedge clk);
        req_valid = 2'b10; req_signed = 2'b10; req_x = {32'hFFFF_FFF9, 32'd0}; req_y = {32'd2, 32'd0};
        #1;
        chk("s2_ready", req_ready, 2'b10);
        chk("s2_signed", dv_signed, 1);
        @(negedge clk);
        req_valid = 0;
        repeat (17) @(negedge clk);
        #1;
        chk("s2_rsp_valid", rsp_valid, 2'b10);
        chk("s2_q", rsp_q, 32'hFFFF_FFFD);
        chk("s2_r", rsp_r, 32'hFFFF_FFFF);
        wait_idle("s2_idle");

        // Both requesting continuously: grants alternate starting with port 0
        req_signed = 0; req_x = {32'd50, 32'd20}; req_y = {32'd5, 32'd3};
        ng = 0;
        repeat (60) begin
            @(negedge clk);
            req_valid = 2'b11;
            #1;
            if (dv_div && ng < 4) begin
                g[ng] = req_ready;
                ng++;
            end
        end
        @(negedge clk);
        req_valid = 0;
        chk("s3_ngrants", ng, 4);
        chk("s3_g0", g[0], 2'b01);
        chk("s3_g1", g[1], 2'b10);
        chk("s3_g2", g[2], 2'b01);
        chk("s3_g3", g[3], 2'b10);
        wait_idle("s3_idle");

        // Flush of the owner mid-RUN; foreign flush ignored; pending port 1 granted after
        @(negedge clk);
        req_valid = 2'b11; req_x = {32'd50, 32'd40}; req_y = {32'd5, 32'd6};
        #1;
        chk("s4_ready", req_ready, 2'b01);
        chk("s4_x", dv_x, 40);
        @(negedge clk);
        req_valid = 2'b10;
        #1;
        chk("s4_ready_busy", req_ready, 0);
        @(negedge clk);
        flush = 2'b10;
        #1;
        chk("s4_foreign_cancel", dv_cancel, 0);
        @(negedge clk);
        flush = 0;
        #1;
        chk("s4_still_busy", busy, 1);
        @(negedge clk);
        @(negedge clk);
        flush = 2'b01;
        #1;
        chk("s4_cancel", dv_cancel, 1);
        chk("s4_no_rsp", rsp_valid, 0);
        @(negedge clk);
        flush = 0;
        #1;
        chk("s4_idle", busy, 0);
        chk("s4_ready1", req_ready, 2'b10);
        chk("s4_div1", dv_div, 1);
        chk("s4_x1", dv_x, 50);
        @(negedge clk);
        req_valid = 0;
        repeat (17) @(negedge clk);
        #1;
        chk("s4_rsp_valid", rsp_valid, 2'b10);
        chk("s4_q", rsp_q, 10);
        chk("s4_r", rsp_r, 0);
        wait_idle("s4_done");

        // Divide by zero with a held response
        @(negedge clk);
        req_valid = 2'b01; req_signed = 0; req_x = {32'd0, 32'd123}; req_y = 0; rsp_ready = 0;
        @(negedge clk);
        req_valid = 0;
        repeat (17) @(negedge clk);
        #1;
        chk("s5_rsp_valid", rsp_valid, 2'b01);
        chk("s5_dbz", rsp_dbz, 1);
        chk("s5_q", rsp_q, 32'hFFFF_FFFF);
        chk("s5_r", rsp_r, 123);
        stable = 1; seen = 0;
        req_y = {32'd0, 32'd5};
        repeat (10) begin
            @(negedge clk);
            req_valid = 2'b01;
            #1;
            stable &= (rsp_q == 32'hFFFF_FFFF) && (rsp_r == 123) && (rsp_valid == 2'b01);
            seen |= dv_div | (|req_ready);
        end
        chk("s5_stable", stable, 1);
        chk("s5_no_grant", seen, 0);
        @(negedge clk);
        req_valid = 0; rsp_ready = 2'b01;
        @(negedge clk);
        #1;
        chk("s5_idle", busy, 0);

        // Flushed requester is not granted in IDLE
        @(negedge clk);
        req_valid = 2'b01; flush = 2'b01;
        #1;
        chk("s6_flush_ready", req_ready, 0);
        chk("s6_flush_div", dv_div, 0);
        req_valid = 0; flush = 0;

        // Asynchronous reset mid-RUN
        @(negedge clk);
        req_valid = 2'b10; req_signed = 2'b10; req_x = {32'd9, 32'd0}; req_y = {32'd2, 32'd0}; rsp_ready = 2'b11;
        @(negedge clk);
        req_valid = 0;
        repeat (4) @(negedge clk);
        #3;
        resetn = 0;
        #1;
        chk("s7_busy", busy, 0);
        chk("s7_rsp_valid", rsp_valid, 0);
        chk("s7_cancel", dv_cancel, 0);
        chk("s7_q", rsp_q, 0);
        chk("s7_r", rsp_r, 0);
        chk("s7_dbz", rsp_dbz, 0);
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        req_valid = 2'b11; req_signed = 0; req_x = {32'd1, 32'd100}; req_y = {32'd1, 32'd7};
        #1;
        chk("s7_first_port0", req_ready, 2'b01);
        @(negedge clk);
        req_valid = 0;
        repeat (17) @(negedge clk);
        #1;
        chk("s7_rsp_valid", rsp_valid, 2'b01);
        chk("s7_q2", rsp_q, 14);
        chk("s7_r2", rsp_r, 2);
        wait_idle("s7_idle");

        chk("protocol_viol", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
